// File: rtl/frame_sync_source_mux.sv
// Frame-synchronous selector for NUM_SRC RGB video sources feeding the VGA colour inputs.
// A debounced selector change is committed only on frame_start, optionally followed by black frames.
module frame_sync_source_mux #(
   parameter int NUM_SRC       = 8,
   parameter int COLOR_W       = 8,
   parameter int SEL_W         = $clog2(NUM_SRC),
   parameter int STABLE_CYCLES = 16,
   parameter int BLANK_FRAMES  = 1,
   parameter int INIT_SEL      = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_SRC*3*COLOR_W-1:0]   src_rgb,
   input  logic [SEL_W-1:0]               sel_req,
   input  logic                           frame_start,
   output logic [3*COLOR_W-1:0]           out_rgb,
   output logic [SEL_W-1:0]               active_sel,
   output logic                           switching,
   output logic [1:0]                     dbg_state
);

   localparam int PIX_W = 3 * COLOR_W;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [SEL_W:0]   SEL_RANGE  = (SEL_W + 1)'(NUM_SRC);
   localparam logic [SEL_W-1:0] INIT       = SEL_W'(INIT_SEL);
   localparam logic [3:0]       BLANK_INIT = 4'(BLANK_FRAMES);

   // Handshake-free block: frame_start is a single-cycle strobe, sampled on the
   // rising clk edge; sel_req is level-sampled every cycle with no acknowledge.

   typedef enum logic [1:0] {
      SHOW       = 2'd0,
      WAIT_FRAME = 2'd1,
      BLANK      = 2'd2
   } state_t;

   state_t             state_q;
   logic [SEL_W-1:0]   sel_prev_q;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic [SEL_W-1:0]   stable_sel_q, stable_sel_d;
   logic [SEL_W-1:0]   active_sel_q;
   logic [SEL_W-1:0]   pending_sel_q;
   logic [3:0]         frame_cnt_q;
   logic [PIX_W-1:0]   out_rgb_q;
   logic               sel_in_range;

   assign sel_in_range = ({1'b0, sel_req} < SEL_RANGE);

   // Counter value k-1 marks the k-th consecutive equal in-range sample.
   always_comb begin
      cnt_d        = cnt_q;
      stable_sel_d = stable_sel_q;
      if ((sel_req != sel_prev_q) || !sel_in_range) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (sel_in_range && (cnt_d == CNT_LAST)) begin
         stable_sel_d = sel_req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_prev_q   <= INIT;
         cnt_q        <= '0;
         stable_sel_q <= INIT;
      end else begin
         sel_prev_q   <= sel_req;
         cnt_q        <= cnt_d;
         stable_sel_q <= stable_sel_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= SHOW;
         active_sel_q  <= INIT;
         pending_sel_q <= INIT;
         frame_cnt_q   <= '0;
         out_rgb_q     <= '0;
      end else begin
         // Output uses the pre-edge state and selection, giving one clk of latency.
         out_rgb_q <= (state_q == BLANK) ? '0
                                         : src_rgb[PIX_W*int'(active_sel_q) +: PIX_W];
         case (state_q)
            SHOW: begin
               if (stable_sel_q != active_sel_q) begin
                  pending_sel_q <= stable_sel_q;
                  state_q       <= WAIT_FRAME;
               end
            end
            WAIT_FRAME: begin
               pending_sel_q <= stable_sel_q;
               if (stable_sel_q == active_sel_q) begin
                  state_q <= SHOW;
               end else if (frame_start) begin
                  active_sel_q <= pending_sel_q;
                  if (BLANK_FRAMES == 0) begin
                     state_q <= SHOW;
                  end else begin
                     frame_cnt_q <= BLANK_INIT;
                     state_q     <= BLANK;
                  end
               end
            end
            BLANK: begin
               if (frame_start) begin
                  if (frame_cnt_q <= 4'd1) begin
                     frame_cnt_q <= '0;
                     state_q     <= SHOW;
                  end else begin
                     frame_cnt_q <= frame_cnt_q - 4'd1;
                  end
               end
            end
            default: state_q <= SHOW;
         endcase
      end
   end

   assign out_rgb    = out_rgb_q;
   assign active_sel = active_sel_q;
   assign switching  = (state_q != SHOW);
   assign dbg_state  = state_q;

endmodule

// File: doc/frame_sync_source_mux.md
Name: frame_sync_source_mux

Overview:
- Parametrised successor to the fixed 8-way switch-driven colour mux that feeds the VGA controller.
- Selects one of NUM_SRC RGB video sources, each a game or test pattern.
- Debounces the raw selector and changes source only on a frame boundary, so there is no mid-frame tearing.
- Optionally forces BLANK_FRAMES black frames between sources. Output is registered and feeds the VGA controller's colour inputs directly.

Parameters:
NUM_SRC, 8, number of video sources (2..16)
COLOR_W, 8, bits per colour channel
SEL_W, $clog2(NUM_SRC), selector width
STABLE_CYCLES, 16, consecutive clk cycles sel_req must hold before it is accepted (1..65535)
BLANK_FRAMES, 1, number of black frames inserted on a source change (0..15)
INIT_SEL, 0, source shown after reset (< NUM_SRC)

Ports:
clk  input  1  system clock (50 MHz domain)
rst  input  1  asynchronous, active-high reset
src_rgb  input  NUM_SRC*3*COLOR_W  packed sources; source i occupies bits [(i+1)*3*COLOR_W-1 : i*3*COLOR_W], ordered {R,G,B} with R in the MSBs
sel_req  input  SEL_W  raw selector (switches)
frame_start  input  1  one-cycle pulse at the first clk of vertical blanking
out_rgb  output  3*COLOR_W  selected pixel {R,G,B}, registered
active_sel  output  SEL_W  source currently routed to out_rgb
switching  output  1  high while a change is pending or blanking is in progress

Behaviour:
- Reset (async assert, sync release):
  - out_rgb=0, active_sel=INIT_SEL, switching=0, state=SHOW.
  - stable_sel=INIT_SEL, pending_sel=INIT_SEL, debounce counter=0, frame counter=0.
  - Reset asserted mid-switch aborts the switch; no partial state survives.
- Debounce:
  - Sample sel_req every clk and compare with the previous sample.
  - If the sample differs, or is >= NUM_SRC, the counter is cleared to 0.
  - Otherwise the counter saturates at STABLE_CYCLES.
  - stable_sel loads the sample on the cycle the counter reaches STABLE_CYCLES-1, i.e. after STABLE_CYCLES equal in-range samples.
  - Out-of-range values are never accepted.
- FSM states SHOW, WAIT_FRAME, BLANK:
  - SHOW: if stable_sel != active_sel, then pending_sel<=stable_sel and go to WAIT_FRAME. A frame_start in the same cycle is not used; the change waits for the next pulse.
  - WAIT_FRAME: pending_sel tracks stable_sel every cycle.
    - If stable_sel returns to active_sel before a frame_start, go back to SHOW with no change.
    - On frame_start with BLANK_FRAMES==0: active_sel<=pending_sel, go to SHOW.
    - On frame_start with BLANK_FRAMES>0: active_sel<=pending_sel, frame counter<=BLANK_FRAMES, go to BLANK.
  - BLANK: each frame_start decrements the counter. A frame_start seen with counter==1 returns to SHOW. Selector changes are ignored here and re-evaluated in SHOW.
- Output:
  - out_rgb <= (state==BLANK) ? 0 : source[active_sel]. The state and active_sel used are the values before the clock edge.
  - Latency is exactly 1 clk from src_rgb to out_rgb.
  - The first new-source pixel appears 2 clk after the frame_start that commits the switch.
- switching = (state != SHOW). It is registered with the state.
- Widths: no arithmetic on colour data; pure selection or zero.

Test Plan:
- Reset with INIT_SEL=3 and src3={8'h12,8'h34,8'h56}, then release -> one clk later out_rgb=24'h123456, active_sel=3, switching=0.
- STABLE_CYCLES=16: toggle sel_req between 3 and 5 every 10 clk for 200 clk -> active_sel stays 3, switching stays 0.
- BLANK_FRAMES=0: hold sel_req=5 for 16 clk, then pulse frame_start at clk 100 -> switching=1 from debounce acceptance until 1 clk after the pulse; out_rgb=src5 starting clk 102, no black pixels.
- BLANK_FRAMES=2: same request with frame_start pulses at clk 100, 1000 and 2000 -> active_sel=5 after clk 100; out_rgb=0 from clk 102 to clk 2001; src5 from clk 2002; switching falls after the clk 2000 pulse.
- NUM_SRC=8, sel_req=7 held in range, then sel_req forced to an illegal value with NUM_SRC=6 -> never accepted, active_sel unchanged. Request withdrawn in WAIT_FRAME before frame_start -> return to SHOW, no blank frames.
- Assert rst during BLANK -> immediately out_rgb=0, state SHOW, active_sel=INIT_SEL, switching=0.
